// File: rtl/game_pkg.sv
// Shared game definitions: player motion states and physics/sprite defaults
// used by the motion stage, the collider and the draw logic.
package game_pkg;

    // state    | meaning
    // GROUNDED | standing on the floor bound, may start a jump
    // RISING   | moving up after a jump, gravity slowing the ascent
    // FALLING  | moving down, speed saturating at the terminal value
    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_state_t;

    localparam int PLAYER_W_DEF = 32;
    localparam int PLAYER_H_DEF = 48;
    localparam int X_STEP_DEF   = 2;
    localparam int JUMP_V_DEF   = 12;
    localparam int GRAVITY_DEF  = 1;
    localparam int MAX_FALL_DEF = 8;

endpackage

// File: rtl/player_motion_frame_tick_gen.sv
// Rising-edge detector on the frame clock, gated by freeze, producing a
// one-Clk-wide update strobe.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic frame_clk,
    input  logic freeze,
    output logic tick
);

    logic frame_clk_prev_d;
    logic frame_clk_prev_q;

    // Previous frame_clk sample follows the input every cycle.
    always_comb begin
        frame_clk_prev_d = frame_clk;
    end

    // Register the previous frame_clk sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_clk_prev_q <= 1'b0;
        end else begin
            frame_clk_prev_q <= frame_clk_prev_d;
        end
    end

    assign tick = frame_clk & ~frame_clk_prev_q & ~freeze;

endmodule

// File: rtl/player_motion.sv
// Per-player motion stage: registered position, horizontal walking, jump and
// gravity, all clamped to the collider bounds sampled on each frame tick.
//
// state    | meaning
// GROUNDED | on the floor; jump edge launches, missing floor starts a fall
// RISING   | ascending; ceiling hit or apex switches to FALLING
// FALLING  | descending with capped speed; reaching the floor lands
module player_motion
    import game_pkg::*;
#(
    parameter int INIT_X   = 64,
    parameter int INIT_Y   = 415,
    parameter int PLAYER_W = PLAYER_W_DEF,
    parameter int PLAYER_H = PLAYER_H_DEF,
    parameter int X_STEP   = X_STEP_DEF,
    parameter int JUMP_V   = JUMP_V_DEF,
    parameter int GRAVITY  = GRAVITY_DEF,
    parameter int MAX_FALL = MAX_FALL_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               freeze,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_jump,
    input  logic signed [31:0] player_X_Min,
    input  logic signed [31:0] player_X_Max,
    input  logic signed [31:0] player_Y_Min,
    input  logic signed [31:0] player_Y_Max,
    output logic signed [31:0] player_X_Pos,
    output logic signed [31:0] player_Y_Pos,
    output logic signed [31:0] player_vy,
    output logic [1:0]         motion_state,
    output logic               facing_left
);

    logic tick;

    logic signed [31:0] x_d, x_q;
    logic signed [31:0] y_d, y_q;
    logic signed [31:0] vy_d, vy_q;
    motion_state_t      state_d, state_q;
    logic               facing_left_d, facing_left_q;
    logic               jump_prev_d, jump_prev_q;

    logic signed [31:0] dx, nx, ny, vy_n;
    logic               jump_edge;

    frame_tick_gen u_tick (
        .clk       (Clk),
        .reset     (Reset),
        .frame_clk (frame_clk),
        .freeze    (freeze),
        .tick      (tick)
    );

    // Next position/velocity/state on a tick; otherwise everything holds.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        vy_d          = vy_q;
        state_d       = state_q;
        facing_left_d = facing_left_q;
        jump_prev_d   = jump_prev_q;
        dx            = '0;
        nx            = x_q;
        ny            = y_q;
        vy_n          = vy_q;
        jump_edge     = key_jump & ~jump_prev_q;

        if (tick) begin
            jump_prev_d = key_jump;

            if (key_left && !key_right) begin
                dx            = -X_STEP;
                facing_left_d = 1'b1;
            end else if (key_right && !key_left) begin
                dx            = X_STEP;
                facing_left_d = 1'b0;
            end

            // Inverted horizontal bounds freeze X rather than snapping it.
            if (player_X_Min <= player_X_Max - PLAYER_W) begin
                nx = x_q + dx;
                if (nx < player_X_Min) begin
                    nx = player_X_Min;
                end else if (nx + PLAYER_W > player_X_Max) begin
                    nx = player_X_Max - PLAYER_W;
                end
                x_d = nx;
            end

            if (player_Y_Min <= player_Y_Max - PLAYER_H) begin
                case (state_q)
                    GROUNDED: begin
                        if (jump_edge) begin
                            ny = y_q - JUMP_V;
                            if (ny < player_Y_Min) begin
                                y_d     = player_Y_Min;
                                vy_d    = '0;
                                state_d = FALLING;
                            end else begin
                                y_d     = ny;
                                vy_d    = -JUMP_V;
                                state_d = RISING;
                            end
                        end else if (y_q + PLAYER_H < player_Y_Max) begin
                            vy_d    = '0;
                            state_d = FALLING;
                        end
                    end
                    RISING: begin
                        vy_n = vy_q + GRAVITY;
                        ny   = y_q + vy_n;
                        if (ny < player_Y_Min) begin
                            y_d     = player_Y_Min;
                            vy_d    = '0;
                            state_d = FALLING;
                        end else begin
                            y_d  = ny;
                            vy_d = vy_n;
                            if (vy_n >= 0) begin
                                state_d = FALLING;
                            end
                        end
                    end
                    FALLING: begin
                        vy_n = vy_q + GRAVITY;
                        if (vy_n > MAX_FALL) begin
                            vy_n = MAX_FALL;
                        end
                        ny = y_q + vy_n;
                        if (ny + PLAYER_H >= player_Y_Max) begin
                            y_d     = player_Y_Max - PLAYER_H;
                            vy_d    = '0;
                            state_d = GROUNDED;
                        end else begin
                            y_d  = ny;
                            vy_d = vy_n;
                        end
                    end
                    default: begin
                        state_d = GROUNDED;
                        vy_d    = '0;
                    end
                endcase
            end
        end
    end

    // Motion registers; synchronous reset takes priority over a tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q           <= INIT_X;
            y_q           <= INIT_Y;
            vy_q          <= '0;
            state_q       <= GROUNDED;
            facing_left_q <= 1'b0;
            jump_prev_q   <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            vy_q          <= vy_d;
            state_q       <= state_d;
            facing_left_q <= facing_left_d;
            jump_prev_q   <= jump_prev_d;
        end
    end

    assign player_X_Pos = x_q;
    assign player_Y_Pos = y_q;
    assign player_vy    = vy_q;
    assign motion_state = state_q;
    assign facing_left  = facing_left_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed table, hand-written jump,
// ceiling, freeze and reset sequences, then randomized traffic against a
// rule-level reference model.
module tb_player_motion;

    localparam int W = 32, H = 48, STEP = 2, JV = 12, G = 1, MAXF = 8;

    logic Clk = 1'b0;
    logic Reset, frame_clk, freeze, key_left, key_right, key_jump;
    int   x_min, x_max, y_min, y_max;
    logic signed [31:0] x_pos, y_pos, vy;
    logic [1:0] mstate;
    logic       fleft;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    player_motion dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .freeze       (freeze),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_jump     (key_jump),
        .player_X_Min (x_min),
        .player_X_Max (x_max),
        .player_Y_Min (y_min),
        .player_Y_Max (y_max),
        .player_X_Pos (x_pos),
        .player_Y_Pos (y_pos),
        .player_vy    (vy),
        .motion_state (mstate),
        .facing_left  (fleft)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int ex, input int ey,
                           input int evy, input int est, input int efl);
        chk({name, ".x"}, x_pos, ex);
        chk({name, ".y"}, y_pos, ey);
        chk({name, ".vy"}, vy, evy);
        chk({name, ".state"}, int'(mstate), est);
        chk({name, ".facing"}, int'(fleft), efl);
    endtask

    // One frame tick: raise frame_clk, drop it, sample at the following negedge.
    task automatic do_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
    endtask

    // Reference model: player state in plain integers, stepped by the rules.
    int m_x, m_y, m_vy, m_st, m_fl, m_jprev, m_fprev;

    task automatic model_reset();
        m_x = 64; m_y = 415; m_vy = 0; m_st = 0; m_fl = 0; m_jprev = 0; m_fprev = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j,
                              input int xmn, input int xmx, input int ymn, input int ymx);
        int dxm, nxm, nym, v;
        bit je;
        dxm = 0;
        if (l && !r) begin dxm = -STEP; m_fl = 1; end
        else if (r && !l) begin dxm = STEP; m_fl = 0; end
        if (xmn <= xmx - W) begin
            nxm = m_x + dxm;
            if (nxm < xmn) nxm = xmn;
            else if (nxm + W > xmx) nxm = xmx - W;
            m_x = nxm;
        end
        je = j && !m_jprev;
        m_jprev = j;
        if (ymn <= ymx - H) begin
            if (m_st == 0) begin
                if (je) begin
                    nym = m_y - JV;
                    if (nym < ymn) begin m_y = ymn; m_vy = 0; m_st = 2; end
                    else begin m_y = nym; m_vy = -JV; m_st = 1; end
                end else if (m_y + H < ymx) begin
                    m_vy = 0; m_st = 2;
                end
            end else if (m_st == 1) begin
                v = m_vy + G;
                nym = m_y + v;
                if (nym < ymn) begin m_y = ymn; m_vy = 0; m_st = 2; end
                else begin m_y = nym; m_vy = v; if (v >= 0) m_st = 2; end
            end else begin
                v = (m_vy + G > MAXF) ? MAXF : m_vy + G;
                nym = m_y + v;
                if (nym + H >= ymx) begin m_y = ymx - H; m_vy = 0; m_st = 0; end
                else begin m_y = nym; m_vy = v; end
            end
        end
    endtask

    typedef struct {
        bit l, r, j;
        int xmn, xmx, ymn, ymx;
        int ex, ey, evy, est, efl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit l, bit r, bit j, int xmn, int xmx,
                                int ex, int efl);
        vec_t v;
        v.l = l; v.r = r; v.j = j;
        v.xmn = xmn; v.xmx = xmx; v.ymn = 30; v.ymx = 463;
        v.ex = ex; v.ey = 415; v.evy = 0; v.est = 0; v.efl = efl;
        return v;
    endfunction

    int ys[30], vys[30], sts[30];
    int max_vy;

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; freeze = 1'b0;
        key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
        x_min = 0; x_max = 640; y_min = 30; y_max = 463;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_all("reset", 64, 415, 0, 0, 0);

        // Idle, walk right into a wall, walk left into a wall, both keys.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 463, 64, 0));
        vecs.push_back(mk(0, 1, 0, 0, 100, 66, 0));
        vecs.push_back(mk(0, 1, 0, 0, 100, 68, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 0, 100, 68, 0));
        vecs.push_back(mk(1, 0, 0, 60, 640, 66, 1));
        vecs.push_back(mk(1, 0, 0, 60, 640, 64, 1));
        vecs.push_back(mk(1, 0, 0, 60, 640, 62, 1));
        vecs.push_back(mk(1, 0, 0, 60, 640, 60, 1));
        vecs.push_back(mk(1, 0, 0, 60, 640, 60, 1));
        vecs.push_back(mk(1, 1, 0, 60, 640, 60, 1));
        vecs.push_back(mk(1, 1, 0, 60, 640, 60, 1));
        vecs.push_back(mk(0, 1, 0, 60, 640, 62, 0));
        // Inverted X bounds hold X even with a key held.
        vecs.push_back(mk(0, 1, 0, 100, 110, 62, 0));

        foreach (vecs[k]) begin
            key_left = vecs[k].l; key_right = vecs[k].r; key_jump = vecs[k].j;
            x_min = vecs[k].xmn; x_max = vecs[k].xmx;
            y_min = vecs[k].ymn; y_max = vecs[k].ymx;
            do_tick();
            chk_all($sformatf("vec%0d", k), vecs[k].ex, vecs[k].ey,
                    vecs[k].evy, vecs[k].est, vecs[k].efl);
        end

        // Full jump arc with the key held throughout.
        key_left = 0; key_right = 0; key_jump = 1;
        x_min = 0; x_max = 640; y_min = 30; y_max = 463;
        max_vy = -100;
        for (int i = 0; i < 30; i++) begin
            do_tick();
            ys[i] = y_pos; vys[i] = vy; sts[i] = mstate;
            if (vy > max_vy) max_vy = vy;
        end
        chk("jump.y0", ys[0], 403);
        chk("jump.st0", sts[0], 1);
        chk("jump.y1", ys[1], 392);
        chk("jump.y2", ys[2], 382);
        chk("jump.peak_y", ys[12], 337);
        chk("jump.peak_vy", vys[12], 0);
        chk("jump.peak_st", sts[12], 2);
        chk("jump.max_fall", max_vy, 8);
        chk("jump.y24", ys[24], 405);
        chk("jump.land_y", ys[26], 415);
        chk("jump.land_st", sts[26], 0);
        chk("jump.no_rejump_y", ys[29], 415);
        chk("jump.no_rejump_st", sts[29], 0);

        // Ceiling clamp.
        key_jump = 0;
        do_tick();
        key_jump = 1; y_min = 400;
        do_tick();
        chk_all("ceil.launch", 62, 403, -12, 1, 0);
        do_tick();
        chk_all("ceil.clamp", 62, 400, 0, 2, 0);
        repeat (4) do_tick();
        chk_all("ceil.fall4", 62, 410, 4, 2, 0);
        do_tick();
        chk_all("ceil.land", 62, 415, 0, 0, 0);

        // Freeze mid-air, then reset in the same cycle as a tick.
        key_jump = 0; y_min = 30;
        do_tick();
        key_jump = 1;
        repeat (3) do_tick();
        chk_all("frz.before", 62, 382, -10, 1, 0);
        freeze = 1;
        repeat (5) do_tick();
        chk_all("frz.held", 62, 382, -10, 1, 0);
        freeze = 0;
        @(negedge Clk) begin Reset = 1'b1; frame_clk = 1'b1; end
        @(posedge Clk); #1;
        chk_all("rst_tick", 64, 415, 0, 0, 0);
        @(negedge Clk) begin Reset = 1'b0; frame_clk = 1'b0; end

        // Randomized traffic against the model.
        key_jump = 0;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit f, fz, rs, t;
            @(negedge Clk);
            rs = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 2) == 0) ? ~frame_clk : frame_clk;
            fz = ($urandom_range(0, 9) == 0);
            key_left  = $urandom_range(0, 1);
            key_right = $urandom_range(0, 1);
            key_jump  = ($urandom_range(0, 3) == 0);
            x_min = m_x - $urandom_range(0, 5);
            x_max = m_x + W + $urandom_range(0, 5);
            if ($urandom_range(0, 15) == 0) x_max = x_min + 10;
            y_max = (m_st == 0 && $urandom_range(0, 3) != 0) ? m_y + H
                                                            : m_y + H + $urandom_range(0, 30);
            y_min = m_y - $urandom_range(0, 30);
            if ($urandom_range(0, 15) == 0) y_min = y_max - 20;
            Reset = rs; frame_clk = f; freeze = fz;
            t = f && !m_fprev && !fz;
            m_fprev = f;
            if (rs) model_reset();
            else if (t) model_tick(key_left, key_right, key_jump, x_min, x_max, y_min, y_max);
            @(posedge Clk); #1;
            if (x_pos != m_x || y_pos != m_y || vy != m_vy || int'(mstate) != m_st ||
                int'(fleft) != m_fl) begin
                n_fail++;
                $display("FAIL rand%0d: got x=%0d y=%0d vy=%0d st=%0d fl=%0d, expected x=%0d y=%0d vy=%0d st=%0d fl=%0d",
                         c, x_pos, y_pos, vy, mstate, fleft, m_x, m_y, m_vy, m_st, m_fl);
            end
            n_tests++;
        end
        Reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
